// File: rtl/traffic_light_multi.sv
// Multi-approach traffic light: round-robin green/yellow/all-red sequencer on a prescaled tick.
// Optional emergency preemption is compiled in when TRAFFIC_EMERGENCY_EN is defined.
module traffic_light_multi #(
  parameter int NUM_DIR      = 4,
  parameter int TICK_DIV     = 4,
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIR-1:0]         sensor,
`ifdef TRAFFIC_EMERGENCY_EN
  input  logic                       emg_req,
  input  logic [$clog2(NUM_DIR)-1:0] emg_dir,
`endif
  output logic [3*NUM_DIR-1:0]       lights,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [1:0]                 phase,
  output logic                       tick
);

  localparam int DW   = $clog2(NUM_DIR);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (GREEN_TICKS > YELLOW_TICKS)
                        ? ((GREEN_TICKS > ALLRED_TICKS) ? GREEN_TICKS : ALLRED_TICKS)
                        : ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS);
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] G_LAST   = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] Y_LAST   = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] A_LAST   = TW'(ALLRED_TICKS - 1);

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    ALLRED = 2'b10
  } state_t;

  state_t               state, state_nx;
  logic [PW-1:0]        div_cnt;
  logic [TW-1:0]        timer, timer_nx;
  logic [DW-1:0]        dir_nx;
  logic [3*NUM_DIR-1:0] lights_nx;
  logic [NUM_DIR-1:0]   others_mask;
  logic                 others_req;
  logic                 emg_force, emg_hold, emg_sel;
  logic [DW-1:0]        emg_dir_i;

  // First requesting approach after cur, wrapping; cur itself if nobody else waits.
  function automatic logic [DW-1:0] rr_pick(input logic [NUM_DIR-1:0] req,
                                            input logic [DW-1:0] cur);
    logic [DW-1:0] pick;
    logic [DW-1:0] idx;
    logic          found;
    pick  = cur;
    found = 1'b0;
    for (int k = 1; k < NUM_DIR; k++) begin
      idx = DW'((int'(cur) + k) % NUM_DIR);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Only the served approach may be non-red; any other state code maps to all-red.
  function automatic logic [3*NUM_DIR-1:0] light_map(input state_t st,
                                                     input logic [DW-1:0] dir);
    logic [3*NUM_DIR-1:0] lm;
    for (int i = 0; i < NUM_DIR; i++) begin
      lm[3*i +: 3] = 3'b100;
      if (DW'(i) == dir) begin
        case (st)
          GREEN:   lm[3*i +: 3] = 3'b001;
          YELLOW:  lm[3*i +: 3] = 3'b010;
          default: lm[3*i +: 3] = 3'b100;
        endcase
      end
    end
    return lm;
  endfunction

`ifdef TRAFFIC_EMERGENCY_EN
  assign emg_force = emg_req && (emg_dir != active_dir);
  assign emg_hold  = emg_req && (emg_dir == active_dir);
  assign emg_sel   = emg_req;
  assign emg_dir_i = emg_dir;
`else
  assign emg_force = 1'b0;
  assign emg_hold  = 1'b0;
  assign emg_sel   = 1'b0;
  assign emg_dir_i = '0;
`endif

  assign tick  = (div_cnt == DIV_LAST);
  assign phase = state;

  always_comb begin
    others_mask             = sensor;
    others_mask[active_dir] = 1'b0;
    others_req              = |others_mask;
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    dir_nx   = active_dir;
    case (state)
      GREEN: begin
        if (emg_force) begin
          state_nx = YELLOW;
          timer_nx = '0;
        end else if (tick) begin
          if (timer == G_LAST) begin
            if (others_req && !emg_hold) begin
              state_nx = YELLOW;
              timer_nx = '0;
            end
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
      end
      YELLOW: begin
        if (tick) begin
          if (timer == Y_LAST) begin
            state_nx = ALLRED;
            timer_nx = '0;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
      end
      ALLRED: begin
        if (tick) begin
          if (timer == A_LAST) begin
            state_nx = GREEN;
            timer_nx = '0;
            dir_nx   = emg_sel ? emg_dir_i : rr_pick(sensor, active_dir);
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
      end
      default: begin
        state_nx = ALLRED;
        timer_nx = '0;
      end
    endcase
    lights_nx = light_map(state_nx, dir_nx);
  end

  // Registered state, timer, served approach and lamp drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      state      <= GREEN;
      timer      <= '0;
      active_dir <= '0;
      lights     <= light_map(GREEN, '0);
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      state      <= state_nx;
      timer      <= timer_nx;
      active_dir <= dir_nx;
      lights     <= lights_nx;
    end
  end

endmodule
